sram_port_arbiter: RTL and testbench

Shares the single external SRAM port (18-bit address, 16-bit data, active-low write enable) between up to NUM_REQ client blocks: UART loader, Milestone 1 colour-space converter, Milestone 2 IDCT and VGA reader. It uses round-robin arbitration with burst ownership and optional forced release. It registers the granted client's access onto the SRAM pins and routes tagged read data back to the issuing client after the fixed SRAM read latency.

---
 rtl/sram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one external SRAM port between NUM_REQ clients.
// Registers the owner's access onto the pins and returns tagged read data after RD_LATENCY edges.
module sram_port_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_HOLD   = 0
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [NUM_REQ-1:0]    Req,
    input  logic [NUM_REQ-1:0]    Req_we_n,
    input  logic [NUM_REQ*18-1:0] Req_address,
    input  logic [NUM_REQ*16-1:0] Req_write_data,
    output logic [NUM_REQ-1:0]    Grant,
    output logic [NUM_REQ-1:0]    Rd_valid,
    output logic [15:0]           Rd_data,
    output logic [17:0]           SRAM_address,
    output logic [15:0]           SRAM_write_data,
    output logic                  SRAM_we_n,
    input  logic [15:0]           SRAM_read_data,
    output logic                  Busy
);

    localparam int unsigned IdW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {StArb, StOwn} state_e;

    state_e                state_q;
    logic [NUM_REQ-1:0]    grant_q;
    logic [NUM_REQ-1:0]    rd_valid_q;
    logic [NUM_REQ-1:0]    rd_valid_d;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [NUM_REQ-1:0]    others;
    logic [IdW-1:0]        rr_ptr_q;
    logic [IdW-1:0]        pick;
    logic [IdW-1:0]        scan_idx;
    logic                  pick_valid;
    logic [HoldW-1:0]      hold_cnt_q;
    logic [HoldW-1:0]      hold_cnt_d;
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [IdW-1:0]        pipe_id_q [RD_LATENCY];
    logic [15:0]           rd_data_q;
    logic [17:0]           sram_addr_q;
    logic [15:0]           sram_wdata_q;
    logic                  sram_we_n_q;
    logic [17:0]           addr_arr  [NUM_REQ];
    logic [15:0]           wdata_arr [NUM_REQ];
    logic                  access;
    logic                  own_we_n;
    logic                  force_rel;

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            addr_arr[k]  = Req_address[18*k +: 18];
            wdata_arr[k] = Req_write_data[16*k +: 16];
        end
    end

    // Scan upward from the slot after the last winner, wrapping once.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        pick_oh    = '0;
        scan_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = IdW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_valid && Req[scan_idx]) begin
                pick_valid        = 1'b1;
                pick              = scan_idx;
                pick_oh[scan_idx] = 1'b1;
            end
        end
    end

    // In StOwn rr_ptr_q names the owner, so it doubles as the access mux select.
    assign own_we_n = Req_we_n[rr_ptr_q];
    assign access   = (state_q == StOwn) && Req[rr_ptr_q];
    assign others   = Req & ~grant_q;

    // hold_cnt saturates so a late-arriving competitor still forces release on the next access.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (32'(hold_cnt_q) < MAX_HOLD) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
        force_rel = (MAX_HOLD != 0) && (|others) && (32'(hold_cnt_d) >= MAX_HOLD);
    end

    always_comb begin
        rd_valid_d = '0;
        rd_valid_d[pipe_id_q[RD_LATENCY-1]] = pipe_vld_q[RD_LATENCY-1];
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= StArb;
            grant_q      <= '0;
            rr_ptr_q     <= IdW'(NUM_REQ - 1);
            hold_cnt_q   <= '0;
            pipe_vld_q   <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_id_q[i] <= '0;
            end
            rd_valid_q   <= '0;
            rd_data_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_n_q  <= 1'b1;
        end else begin
            pipe_vld_q[0] <= access & own_we_n;
            pipe_id_q[0]  <= rr_ptr_q;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
            rd_valid_q <= rd_valid_d;
            if (pipe_vld_q[RD_LATENCY-1]) begin
                rd_data_q <= SRAM_read_data;
            end

            sram_we_n_q <= 1'b1;
            if (access) begin
                sram_addr_q  <= addr_arr[rr_ptr_q];
                sram_wdata_q <= wdata_arr[rr_ptr_q];
                sram_we_n_q  <= own_we_n;
            end

            case (state_q)
                StArb: begin
                    if (pick_valid) begin
                        grant_q    <= pick_oh;
                        rr_ptr_q   <= pick;
                        hold_cnt_q <= '0;
                        state_q    <= StOwn;
                    end
                end
                StOwn: begin
                    if (!access) begin
                        grant_q <= '0;
                        state_q <= StArb;
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                        if (force_rel) begin
                            grant_q <= '0;
                            state_q <= StArb;
                        end
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

    assign Grant           = grant_q;
    assign Rd_valid        = rd_valid_q;
    assign Rd_data         = rd_data_q;
    assign SRAM_address    = sram_addr_q;
    assign SRAM_write_data = sram_wdata_q;
    assign SRAM_we_n       = sram_we_n_q;
    assign Busy            = (state_q != StArb) || (|pipe_vld_q);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random client traffic checked every
// cycle against a transaction-level model of ownership, pin loads and read returns.
module tb_sram_port_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int MH  = 4;

    logic            Clock = 1'b0;
    logic            Resetn = 1'b1;
    logic [N-1:0]    Req = '0;
    logic [N-1:0]    Req_we_n = '1;
    logic [N*18-1:0] Req_address = '0;
    logic [N*16-1:0] Req_write_data = '0;
    logic [N-1:0]    Grant;
    logic [N-1:0]    Rd_valid;
    logic [15:0]     Rd_data;
    logic [17:0]     SRAM_address;
    logic [15:0]     SRAM_write_data;
    logic            SRAM_we_n;
    logic [15:0]     SRAM_read_data;
    logic            Busy;

    sram_port_arbiter #(
        .NUM_REQ    (N),
        .RD_LATENCY (LAT),
        .MAX_HOLD   (MH)
    ) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .Req             (Req),
        .Req_we_n        (Req_we_n),
        .Req_address     (Req_address),
        .Req_write_data  (Req_write_data),
        .Grant           (Grant),
        .Rd_valid        (Rd_valid),
        .Rd_data         (Rd_data),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data),
        .Busy            (Busy)
    );

    always #5 Clock = ~Clock;

    // External SRAM: contents stored xor a pattern so unwritten words read back non-zero.
    function automatic logic [15:0] pat(input logic [17:0] a);
        return 16'(a * 7) ^ 16'h5A5A;
    endfunction

    bit [15:0]   sram_mem [262144];
    logic [15:0] rd_q;
    always @(posedge Clock) begin
        if (!SRAM_we_n) sram_mem[SRAM_address] <= SRAM_write_data ^ pat(SRAM_address);
        rd_q <= sram_mem[SRAM_address] ^ pat(SRAM_address);
    end
    assign SRAM_read_data = rd_q;

    // Client jobs
    int          cl_n [N];
    int          cl_renew [N];
    logic [17:0] cl_addr [N];
    logic        cl_wen [N];
    logic [15:0] cl_data [N];

    // Reference model
    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } rd_t;
    rd_t         rq [$];
    bit [15:0]   shadow [262144];
    int          m_owner, m_rr, m_hold, cyc;
    logic [17:0] exp_addr;
    logic [15:0] exp_wd, exp_rdd;
    logic        exp_we;
    logic [N-1:0] exp_rv;

    // Observations
    int          n_chk = 0;
    int          n_err = 0;
    int          glog [$];
    int          rv_cnt [N];
    int          acc_cnt [N];
    logic [15:0] last_rd [N];
    int          n_wr_obs;
    logic [N-1:0] g_prev_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            Req[k]                  = (cl_n[k] > 0);
            Req_we_n[k]             = cl_wen[k];
            Req_address[18*k +: 18] = cl_addr[k];
            Req_write_data[16*k +: 16] = cl_data[k];
        end
    endtask

    task automatic start_job(input int k, input int n, input logic [17:0] a, input logic wen,
                             input logic [15:0] d, input int renew);
        cl_n[k] = n; cl_addr[k] = a; cl_wen[k] = wen; cl_data[k] = d; cl_renew[k] = renew;
        drive();
    endtask

    task automatic clear_obs();
        glog.delete();
        n_wr_obs = 0;
        for (int k = 0; k < N; k++) begin
            rv_cnt[k] = 0; acc_cnt[k] = 0; last_rd[k] = '0;
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = N - 1; m_hold = 0; rq.delete();
        exp_addr = '0; exp_wd = '0; exp_we = 1'b1; exp_rdd = '0; exp_rv = '0;
    endtask

    // One edge of the abstract model: r is the request vector the DUT sampled.
    task automatic model_edge(input logic [N-1:0] r);
        logic [N-1:0] rest;
        rd_t          e;
        int           k;
        cyc++;
        exp_rv = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            exp_rv[e.id] = 1'b1;
            exp_rdd = e.data;
        end
        exp_we = 1'b1;
        if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                if (m_owner < 0 && r[(m_rr + i) % N]) m_owner = (m_rr + i) % N;
            end
            if (m_owner >= 0) begin
                m_rr = m_owner; m_hold = 0;
            end
        end else if (r[m_owner]) begin
            k = m_owner;
            exp_addr = cl_addr[k]; exp_wd = cl_data[k]; exp_we = cl_wen[k];
            if (!cl_wen[k]) shadow[cl_addr[k]] = cl_data[k] ^ pat(cl_addr[k]);
            else rq.push_back('{cyc + LAT, k, shadow[cl_addr[k]] ^ pat(cl_addr[k])});
            m_hold++;
            rest = r; rest[k] = 1'b0;
            if (MH > 0 && m_hold >= MH && rest != 0) m_owner = -1;
        end else begin
            m_owner = -1;
        end
    endtask

    task automatic tick();
        logic [N-1:0] g_pre, r_pre, exp_g;
        g_pre = Grant; r_pre = Req;
        @(posedge Clock);
        model_edge(r_pre);
        #1;
        exp_g = '0;
        if (m_owner >= 0) exp_g[m_owner] = 1'b1;
        chk("grant", 32'(Grant), 32'(exp_g));
        chk("sram_we_n", 32'(SRAM_we_n), 32'(exp_we));
        chk("sram_addr", 32'(SRAM_address), 32'(exp_addr));
        chk("sram_wdata", 32'(SRAM_write_data), 32'(exp_wd));
        chk("rd_valid", 32'(Rd_valid), 32'(exp_rv));
        chk("busy", 32'(Busy), 32'((m_owner >= 0) || (rq.size() > 0)));
        if (exp_rv != 0) chk("rd_data", 32'(Rd_data), 32'(exp_rdd));
        for (int k = 0; k < N; k++) begin
            if (Grant[k] && g_prev_obs == 0) glog.push_back(k);
            if (Rd_valid[k]) begin
                rv_cnt[k]++; last_rd[k] = Rd_data;
            end
        end
        g_prev_obs = Grant;
        if (!SRAM_we_n) n_wr_obs++;
        for (int k = 0; k < N; k++) begin
            if (g_pre[k] && r_pre[k]) begin
                acc_cnt[k]++; cl_n[k]--; cl_addr[k]++; cl_data[k]++;
            end else if (cl_n[k] == 0 && cl_renew[k] > 0 && !r_pre[k]) begin
                cl_renew[k]--; cl_n[k] = 1;
            end
        end
        drive();
    endtask

    function automatic bit idle();
        bit b = (m_owner < 0) && (rq.size() == 0);
        for (int k = 0; k < N; k++) if (cl_n[k] != 0 || cl_renew[k] != 0) b = 0;
        return b;
    endfunction

    task automatic run_idle(input string tag);
        int b = 0;
        while (!idle() && b < 300) begin
            tick(); b++;
        end
        n_chk++;
        assert (b < 300) else begin
            n_err++;
            $error("FAIL %s_timeout observed=%0d cycles expected=<300", tag, b);
        end
        tick(); tick();
    endtask

    task automatic do_reset();
        #2 Resetn = 1'b0;
        #1;
        chk("rst_grant", 32'(Grant), 32'h0);
        chk("rst_we_n", 32'(SRAM_we_n), 32'h1);
        chk("rst_rd_valid", 32'(Rd_valid), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        for (int k = 0; k < N; k++) begin
            cl_n[k] = 0; cl_renew[k] = 0; cl_addr[k] = '0; cl_wen[k] = 1'b1; cl_data[k] = '0;
        end
        drive();
        model_reset();
        g_prev_obs = '0;
        @(posedge Clock);
        @(posedge Clock);
        #1 Resetn = 1'b1;
        chk("rst_addr", 32'(SRAM_address), 32'h0);
        chk("rst_rd_data", 32'(Rd_data), 32'h0);
        clear_obs();
    endtask

    initial begin
        cyc = 0;
        do_reset();

        // Client 0 back-to-back reads
        start_job(0, 3, 18'd38400, 1'b1, 16'h0, 0);
        tick();
        chk("t1_first_grant", 32'(Grant), 32'h1);
        tick();
        chk("t1_first_addr", 32'(SRAM_address), 32'd38400);
        run_idle("t1");
        chk("t1_rv_count", 32'(rv_cnt[0]), 32'd3);

        // Clients 0 and 2 together: 0 first, gap, then 2
        do_reset();
        start_job(0, 2, 18'd100, 1'b1, 16'h0, 0);
        start_job(2, 1, 18'd200, 1'b1, 16'h0, 0);
        run_idle("t2");
        chk("t2_glog_size", 32'(glog.size()), 32'd2);
        chk("t2_glog0", 32'((glog.size() > 0) ? glog[0] : -1), 32'd0);
        chk("t2_glog1", 32'((glog.size() > 1) ? glog[1] : -1), 32'd2);

        // All clients single-access, re-requesting once
        do_reset();
        for (int k = 0; k < N; k++) start_job(k, 1, 18'(1000 + k), 1'b1, 16'h0, 1);
        run_idle("t3");
        chk("t3_glog_size", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t3_order", 32'((glog.size() > i) ? glog[i] : -1), 32'(i % N));
        end

        // Forced release after MH accesses with a competitor pending
        do_reset();
        start_job(1, 6, 18'd500, 1'b1, 16'h0, 0);
        start_job(3, 1, 18'd700, 1'b1, 16'h0, 0);
        for (int b = 0; b < 30 && !Grant[3]; b++) tick();
        chk("t4_grant3", 32'(Grant[3]), 32'h1);
        chk("t4_hold_accesses", 32'(acc_cnt[1]), 32'(MH));
        run_idle("t4a");
        chk("t4_glog_size", 32'(glog.size()), 32'd3);
        chk("t4_total_acc1", 32'(acc_cnt[1]), 32'd6);
        do_reset();
        start_job(1, 7, 18'd600, 1'b1, 16'h0, 0);
        run_idle("t4b");
        chk("t4_alone_glog", 32'(glog.size()), 32'd1);
        chk("t4_alone_acc", 32'(acc_cnt[1]), 32'd7);

        // Write then read back
        do_reset();
        start_job(2, 1, 18'd146944, 1'b0, 16'hABCD, 0);
        run_idle("t5w");
        chk("t5_write_cycles", 32'(n_wr_obs), 32'd1);
        chk("t5_no_rv_write", 32'(rv_cnt[2]), 32'd0);
        start_job(2, 1, 18'd146944, 1'b1, 16'h0, 0);
        run_idle("t5r");
        chk("t5_rv_count", 32'(rv_cnt[2]), 32'd1);
        chk("t5_rd_data", 32'(last_rd[2]), 32'hABCD);

        // Reset with reads in flight
        do_reset();
        start_job(0, 4, 18'd1234, 1'b1, 16'h0, 0);
        tick(); tick(); tick();
        do_reset();
        repeat (5) tick();
        chk("t6_rv_after_rst", 32'(rv_cnt[0] + rv_cnt[1] + rv_cnt[2] + rv_cnt[3]), 32'd0);
        start_job(3, 1, 18'd10, 1'b1, 16'h0, 0);
        start_job(0, 1, 18'd20, 1'b1, 16'h0, 0);
        tick();
        chk("t6_first_grant", 32'(Grant), 32'h1);
        run_idle("t6");

        // Random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (cl_n[k] == 0 && cl_renew[k] == 0 && $urandom_range(0, 7) == 0)
                    start_job(k, int'($urandom_range(1, 6)), 18'($urandom), 1'($urandom),
                              16'($urandom), 0);
            end
            tick();
        end
        run_idle("rand");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
